// File: rtl/trigger_decoder.sv
// trigger_decoder: missing-tooth crank wheel decoder; define TRIGGER_DECODER_NOISE_FILTER_EN to reject edges closer than a quarter tooth period
module trigger_decoder #(
   parameter int TEETH   = 36,
   parameter int MISSING = 1,
   parameter int PW      = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          vrin,
   output logic          synced,
   output logic          tooth_stb,
   output logic          rev_stb,
   output logic [5:0]    tooth_idx,
   output logic [PW-1:0] tooth_period,
   output logic          sync_err
);
   typedef enum logic [1:0] {SEARCH, VERIFY, SYNCED} state_t;
   localparam logic [PW-1:0] CMAX = '1;
   localparam logic [5:0]    LAST = 6'(TEETH - MISSING - 1);

   state_t        state_q, state_d;
   logic [2:0]    vr_q;
   logic          edge_q;
   logic [PW-1:0] cnt_q, cnt_d, prev_q, prev_d, per_q, per_d;
   logic          vld_q, vld_d, armed_q, armed_d;
   logic [5:0]    idx_q, idx_d;
   logic          tstb_q, tstb_d, rstb_q, rstb_d, err_q, err_d;
   logic          sat, noise, acc, gap, lock, ok;

   assign sat = cnt_q == CMAX;
`ifdef TRIGGER_DECODER_NOISE_FILTER_EN
   assign noise = vld_q && (cnt_q < (prev_q >> 2));
`else
   assign noise = 1'b0;
`endif
   assign acc  = edge_q && !noise;
   assign gap  = vld_q && ({1'b0, cnt_q, 1'b0} > ({2'b0, prev_q} + {1'b0, prev_q, 1'b0}));
   assign lock = state_q != SEARCH;
   assign ok   = lock && (gap == (idx_q == LAST));

   // two-flop synchronizer followed by a registered rising-edge detect
   always_ff @(posedge clk)
      if (reset) begin
         vr_q   <= '0;
         edge_q <= 1'b0;
      end else begin
         vr_q   <= {vr_q[1:0], vrin};
         edge_q <= vr_q[1] & ~vr_q[2];
      end

   // period measurement, gap classification and SEARCH/VERIFY/SYNCED transitions
   always_comb begin
      state_d = state_q;
      cnt_d   = sat ? cnt_q : cnt_q + 1'b1;
      prev_d  = prev_q;
      per_d   = per_q;
      vld_d   = vld_q;
      armed_d = armed_q;
      idx_d   = idx_q;
      tstb_d  = 1'b0;
      rstb_d  = 1'b0;
      err_d   = 1'b0;
      if (sat) begin
         state_d = SEARCH;
         vld_d   = 1'b0;
         armed_d = 1'b0;
         err_d   = lock;
      end
      if (acc) begin
         cnt_d   = PW'(1);
         armed_d = 1'b1;
      end
      if (acc && armed_q && !sat) begin
         if (!gap) begin
            prev_d = cnt_q;
            vld_d  = 1'b1;
         end
         if (ok) begin
            tstb_d  = 1'b1;
            idx_d   = gap ? 6'd0 : idx_q + 1'b1;
            per_d   = gap ? per_q : cnt_q;
            state_d = gap ? SYNCED : state_q;
            rstb_d  = gap && state_q == SYNCED;
         end else if (lock) begin
            state_d = SEARCH;
            err_d   = 1'b1;
         end else if (gap) begin
            state_d = VERIFY;
            idx_d   = 6'd0;
            tstb_d  = 1'b1;
         end
      end
   end

   // state, measurement and output registers
   always_ff @(posedge clk)
      if (reset) begin
         state_q <= SEARCH;
         cnt_q   <= '0;
         prev_q  <= '0;
         per_q   <= '0;
         vld_q   <= 1'b0;
         armed_q <= 1'b0;
         idx_q   <= '0;
         tstb_q  <= 1'b0;
         rstb_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prev_q  <= prev_d;
         per_q   <= per_d;
         vld_q   <= vld_d;
         armed_q <= armed_d;
         idx_q   <= idx_d;
         tstb_q  <= tstb_d;
         rstb_q  <= rstb_d;
         err_q   <= err_d;
      end

   assign synced       = state_q == SYNCED;
   assign tooth_stb    = tstb_q;
   assign rev_stb      = rstb_q;
   assign tooth_idx    = idx_q;
   assign tooth_period = per_q;
   assign sync_err     = err_q;
endmodule
